// File: rtl/adc_pkg.sv
// Shared definitions for the LTC1407A-1 capture engine: frame layout,
// sample width and FSM state encoding.
package adc_pkg;

  localparam int FRAME_LEN = 34;
  localparam int SAMPLE_W  = 14;

  // Sampled-bit positions inside the 34-bit frame (k counts rising SCK edges)
  localparam int A_MSB_IDX = 2;
  localparam int A_LSB_IDX = 15;
  localparam int B_MSB_IDX = 18;
  localparam int B_LSB_IDX = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // True when bit index idx lies within the inclusive range [lo, hi]
  function automatic logic in_range(input logic [5:0] idx, input int lo, input int hi);
    return (int'(idx) >= lo) && (int'(idx) <= hi);
  endfunction

endpackage

// File: rtl/adc_capture_if.sv
// Controller handshake plus ADC serial pins of the capture engine.
// slave = capture engine side, master = controller/ADC side.
interface adc_capture_if;
  import adc_pkg::*;

  logic                adc_trig;
  logic                adc_done;
  logic [SAMPLE_W-1:0] adc_a;
  logic [SAMPLE_W-1:0] adc_b;
  logic                busy;
  logic                ad_conv;
  logic                spi_sck;
  logic                spi_miso;

  modport slave (
    input  adc_trig, spi_miso,
    output adc_done, adc_a, adc_b, busy, ad_conv, spi_sck
  );

  modport master (
    output adc_trig, spi_miso,
    input  adc_done, adc_a, adc_b, busy, ad_conv, spi_sck
  );

endinterface

// File: rtl/sck_gen.sv
// SPI clock generator: while enabled, produces SCK with CLK_DIV cycles low
// then CLK_DIV cycles high, a strobe in the first high cycle, and a flag in
// the last cycle of each period. Held low and cleared when disabled.
module sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic CLK50MHZ,
  input  logic RST,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise_en,
  output logic o_period_end
);

  localparam int               CNT_W    = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sck;
  logic             r_rise;
  logic             w_wrap;

  assign w_wrap = i_en && (r_cnt == CNT_LAST);

  // Half-period counter; SCK toggles each time it wraps
  always_ff @(posedge CLK50MHZ) begin
    if (RST || !i_en) begin
      r_cnt  <= '0;
      r_sck  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      r_rise <= w_wrap && !r_sck;
      if (w_wrap) r_sck <= ~r_sck;
    end
  end

  assign o_sck        = r_sck;
  assign o_rise_en    = r_rise;
  assign o_period_end = w_wrap && r_sck;

endmodule

// File: rtl/adc_capture.sv
// LTC1407A-1 capture engine: on a trigger, strobes AD_CONV, clocks one
// 34-bit SPI frame and presents both 14-bit channels with a one-cycle done.
// Sample bits are passed through untouched (no sign extension).
module adc_capture
  import adc_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int FRAME_LEN = adc_pkg::FRAME_LEN
) (
  input logic          CLK50MHZ,
  input logic          RST,
  adc_capture_if.slave bus
);

  localparam int                CONV_LEN  = 2 * CLK_DIV;
  localparam int                CONV_W    = $clog2(CONV_LEN) + 1;
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_LEN - 1);
  localparam logic [5:0]        BIT_LAST  = 6'(FRAME_LEN - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CONV_W-1:0]   r_conv_cnt;
  logic [5:0]          r_bit_cnt;
  logic [SAMPLE_W-1:0] r_sh_a;
  logic [SAMPLE_W-1:0] r_sh_b;
  logic [SAMPLE_W-1:0] r_adc_a;
  logic [SAMPLE_W-1:0] r_adc_b;
  logic                r_ad_conv;
  logic                r_busy;
  logic                r_done;
  logic                w_conv_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_sck_en;
  logic                w_sck;
  logic                w_rise_en;
  logic                w_period_end;

  assign w_sck_en = (r_state == SHIFT);

  sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .CLK50MHZ     (CLK50MHZ),
    .RST          (RST),
    .i_en         (w_sck_en),
    .o_sck        (w_sck),
    .o_rise_en    (w_rise_en),
    .o_period_end (w_period_end)
  );

  // State register
  always_ff @(posedge CLK50MHZ) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; outputs are registered from the next state so they
  // line up with the state they belong to and leave the block glitch-free
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.adc_trig) w_next = CONV;
      CONV:    if (r_conv_cnt == CONV_LAST) w_next = SHIFT;
      SHIFT:   if (w_period_end && (r_bit_cnt == BIT_LAST)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_conv_nxt = (w_next == CONV);
    w_busy_nxt = (w_next != IDLE);
    w_done_nxt = (w_next == DONE);
  end

  // Conversion-strobe length counter, cleared outside CONV
  always_ff @(posedge CLK50MHZ) begin
    if (RST || (r_state != CONV)) r_conv_cnt <= '0;
    else                          r_conv_cnt <= r_conv_cnt + CONV_W'(1);
  end

  // SCK period index; advances at the end of each period, holds at the last
  always_ff @(posedge CLK50MHZ) begin
    if (RST || (r_state != SHIFT))
      r_bit_cnt <= '0;
    else if (w_period_end && (r_bit_cnt != BIT_LAST))
      r_bit_cnt <= r_bit_cnt + 6'd1;
  end

  // Channel shift registers, MSB first; every frame rewrites all 14 bits
  always_ff @(posedge CLK50MHZ) begin
    if (w_sck_en && w_rise_en) begin
      if (in_range(r_bit_cnt, A_MSB_IDX, A_LSB_IDX))
        r_sh_a <= {r_sh_a[SAMPLE_W-2:0], bus.spi_miso};
      if (in_range(r_bit_cnt, B_MSB_IDX, B_LSB_IDX))
        r_sh_b <= {r_sh_b[SAMPLE_W-2:0], bus.spi_miso};
    end
  end

  // Registered outputs; both samples load together on entry to DONE
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      r_ad_conv <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_adc_a   <= '0;
      r_adc_b   <= '0;
    end else begin
      r_ad_conv <= w_conv_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      if (w_done_nxt) begin
        r_adc_a <= r_sh_a;
        r_adc_b <= r_sh_b;
      end
    end
  end

  assign bus.ad_conv  = r_ad_conv;
  assign bus.busy     = r_busy;
  assign bus.adc_done = r_done;
  assign bus.adc_a    = r_adc_a;
  assign bus.adc_b    = r_adc_b;
  assign bus.spi_sck  = w_sck;

endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: a CLK_DIV=2 instance and a CLK_DIV=1 instance,
// each with a behavioural ADC serialiser and a scoreboard monitor.
`timescale 1ns/1ps
module tb_adc_capture;
  import adc_pkg::*;

  typedef struct {
    int          trig;
    int          done_cyc;
    logic [13:0] a;
    logic [13:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t q_d2[$];
  exp_t q_d1[$];

  logic [33:0] frame_d2 = '0;
  logic [33:0] frame_d1 = '0;

  adc_capture_if bus_d2 ();
  adc_capture_if bus_d1 ();

  adc_capture #(.CLK_DIV(2)) u_dut_d2 (
    .CLK50MHZ (clk),
    .RST      (rst),
    .bus      (bus_d2)
  );

  adc_capture #(.CLK_DIV(1)) u_dut_d1 (
    .CLK50MHZ (clk),
    .RST      (rst),
    .bus      (bus_d1)
  );

  initial forever #10 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [33:0] mkframe(input logic [13:0] a, input logic [13:0] b);
    return {2'b00, a, 2'b00, b, 2'b00};
  endfunction

  // ADC models: bit k is presented while SCK is low before the k-th rising edge
  initial begin
    int rise = 0;
    logic ps = 1'b0;
    bus_d2.spi_miso = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_d2.ad_conv) rise = 0;
      else if (bus_d2.spi_sck && !ps) rise++;
      ps = bus_d2.spi_sck;
      if (!bus_d2.spi_sck && rise < 34) bus_d2.spi_miso = frame_d2[33 - rise];
    end
  end

  initial begin
    int rise = 0;
    logic ps = 1'b0;
    bus_d1.spi_miso = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_d1.ad_conv) rise = 0;
      else if (bus_d1.spi_sck && !ps) rise++;
      ps = bus_d1.spi_sck;
      if (!bus_d1.spi_sck && rise < 34) bus_d1.spi_miso = frame_d1[33 - rise];
    end
  end

  // Monitor, CLK_DIV=2 instance
  initial begin
    int   conv_n = 0, conv_st = 0, sck_n = 0, fr = 0, lr = 0;
    logic ps = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!bus_d2.busy) begin conv_n = 0; sck_n = 0; end
      if (bus_d2.ad_conv) begin if (conv_n == 0) conv_st = cyc; conv_n++; end
      if (bus_d2.spi_sck && !ps) begin if (sck_n == 0) fr = cyc; lr = cyc; sck_n++; end
      ps = bus_d2.spi_sck;
      if (bus_d2.adc_done) begin
        if (q_d2.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL d2_unexpected_done: adc_done at cycle %0d, none expected", cyc);
        end else begin
          e = q_d2.pop_front();
          check("d2_done_cycle", cyc, e.done_cyc);
          check("d2_adc_a", bus_d2.adc_a, e.a);
          check("d2_adc_b", bus_d2.adc_b, e.b);
          check("d2_busy_at_done", bus_d2.busy, 1);
          check("d2_sck_rises", sck_n, 34);
          check("d2_conv_len", conv_n, 4);
          check("d2_conv_start", conv_st, e.trig + 1);
          check("d2_first_rise", fr, e.trig + 7);
          check("d2_rise_span", lr - fr, 132);
        end
        conv_n = 0; sck_n = 0;
      end
    end
  end

  // Monitor, CLK_DIV=1 instance
  initial begin
    int   conv_n = 0, conv_st = 0, sck_n = 0, fr = 0, lr = 0;
    logic ps = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!bus_d1.busy) begin conv_n = 0; sck_n = 0; end
      if (bus_d1.ad_conv) begin if (conv_n == 0) conv_st = cyc; conv_n++; end
      if (bus_d1.spi_sck && !ps) begin if (sck_n == 0) fr = cyc; lr = cyc; sck_n++; end
      ps = bus_d1.spi_sck;
      if (bus_d1.adc_done) begin
        if (q_d1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL d1_unexpected_done: adc_done at cycle %0d, none expected", cyc);
        end else begin
          e = q_d1.pop_front();
          check("d1_done_cycle", cyc, e.done_cyc);
          check("d1_adc_a", bus_d1.adc_a, e.a);
          check("d1_adc_b", bus_d1.adc_b, e.b);
          check("d1_sck_rises", sck_n, 34);
          check("d1_conv_len", conv_n, 2);
          check("d1_conv_start", conv_st, e.trig + 1);
          check("d1_first_rise", fr, e.trig + 4);
          check("d1_rise_span", lr - fr, 66);
        end
        conv_n = 0; sck_n = 0;
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_d2(output int t);
    t = cyc;
    bus_d2.adc_trig = 1'b1;
    @(negedge clk);
    bus_d2.adc_trig = 1'b0;
  endtask

  task automatic pulse_d1(output int t);
    t = cyc;
    bus_d1.adc_trig = 1'b1;
    @(negedge clk);
    bus_d1.adc_trig = 1'b0;
  endtask

  // Stimulus
  initial begin
    int t;
    int t2;
    int act;
    rst = 1'b1;
    bus_d2.adc_trig = 1'b0;
    bus_d1.adc_trig = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and quiet idle
    check("rst_adc_done", bus_d2.adc_done, 0);
    check("rst_adc_a", bus_d2.adc_a, 0);
    check("rst_adc_b", bus_d2.adc_b, 0);
    check("rst_busy", bus_d2.busy, 0);
    check("rst_ad_conv", bus_d2.ad_conv, 0);
    check("rst_spi_sck", bus_d2.spi_sck, 0);
    act = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus_d2.spi_sck || bus_d2.ad_conv || bus_d2.busy || bus_d2.adc_done ||
          (|bus_d2.adc_a) || (|bus_d2.adc_b) ||
          bus_d1.spi_sck || bus_d1.ad_conv || bus_d1.busy || bus_d1.adc_done ||
          (|bus_d1.adc_a) || (|bus_d1.adc_b))
        act++;
    end
    check("idle_activity", act, 0);

    // Single frame
    frame_d2 = mkframe(14'h2A5C, 14'h3FFF);
    pulse_d2(t);
    q_d2.push_back('{trig: t, done_cyc: t + 141, a: 14'h2A5C, b: 14'h3FFF});
    check("busy_after_accept", bus_d2.busy, 1);
    check("ad_conv_cycle1", bus_d2.ad_conv, 1);
    wait_until(t + 142);
    check("busy_after_done", bus_d2.busy, 0);
    check("adc_a_held", bus_d2.adc_a, 14'h2A5C);

    // Ignored-bit positions only
    wait_until(t + 150);
    frame_d2 = {2'b11, 14'h0000, 2'b11, 14'h0000, 2'b11};
    pulse_d2(t);
    q_d2.push_back('{trig: t, done_cyc: t + 141, a: 14'h0000, b: 14'h0000});
    wait_until(t + 150);

    // Trigger while busy is dropped; trigger right after DONE is accepted
    frame_d2 = mkframe(14'h1234, 14'h0ABC);
    pulse_d2(t);
    q_d2.push_back('{trig: t, done_cyc: t + 141, a: 14'h1234, b: 14'h0ABC});
    wait_until(t + 50);
    pulse_d2(t2);
    wait_until(t + 142);
    frame_d2 = mkframe(14'h2001, 14'h1FFE);
    pulse_d2(t2);
    q_d2.push_back('{trig: t2, done_cyc: t + 283, a: 14'h2001, b: 14'h1FFE});
    wait_until(t + 290);

    // Reset mid-frame aborts with no done, then a retrigger completes
    frame_d2 = mkframe(14'h0F0F, 14'h3333);
    pulse_d2(t);
    wait_until(t + 60);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus_d2.busy, 0);
    check("abort_adc_a", bus_d2.adc_a, 0);
    check("abort_adc_b", bus_d2.adc_b, 0);
    check("abort_ad_conv", bus_d2.ad_conv, 0);
    check("abort_spi_sck", bus_d2.spi_sck, 0);
    wait_until(t + 200);
    pulse_d2(t);
    q_d2.push_back('{trig: t, done_cyc: t + 141, a: 14'h0F0F, b: 14'h3333});
    wait_until(t + 150);

    // CLK_DIV=1 instance
    frame_d1 = mkframe(14'h0001, 14'h2000);
    pulse_d1(t);
    q_d1.push_back('{trig: t, done_cyc: t + 71, a: 14'h0001, b: 14'h2000});
    wait_until(t + 72);
    check("d1_busy_after_done", bus_d1.busy, 0);
    frame_d1 = mkframe(14'h3FFE, 14'h1555);
    pulse_d1(t);
    q_d1.push_back('{trig: t, done_cyc: t + 71, a: 14'h3FFE, b: 14'h1555});
    wait_until(t + 80);

    // Every expected completion must have been seen
    check("d2_pending_done", q_d2.size(), 0);
    check("d1_pending_done", q_d1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
